regfile_write_arbiter: RTL and testbench
========================================

// Module: regfile_write_arbiter
// PURPOSE
//  Shares the register file's single write port (regwrite/wa/wd) between two writeback sources:
//   - port A: main pipeline writeback (priority);
//   - port B: multi-cycle unit (mult/div, late loads), buffered in a FIFO.
//  Keeps same-register writes in order, prevents starvation of B, and exports a pending-write
//  scoreboard for hazard logic. Sits between the writeback stage and regfile.
// PARAMETERS
//  DATA_WIDTH   32  width of write data
//  FIFO_DEPTH   4   entries in port-B buffer (power of 2, >=2)
//  STARVE_LIMIT 8   cycles a non-empty FIFO head may wait before a forced B grant
// PORTS
//  clk        in   1           clock; all state updates on rising edge
//  rst_n      in   1           asynchronous active-low reset
//  a_valid    in   1           port A write request
//  a_ready    out  1           port A accepted this cycle when a_valid&a_ready
//  a_wa       in   5           port A destination register
//  a_wd       in   DATA_WIDTH  port A write data
//  b_valid    in   1           port B write request
//  b_ready    out  1           FIFO not full (registered)
//  b_wa       in   5           port B destination register
//  b_wd       in   DATA_WIDTH  port B write data
//  regwrite   out  1           regfile write enable (registered)
//  wa         out  5           regfile write address (registered)
//  wd         out  DATA_WIDTH  regfile write data (registered)
//  pending    out  32          bit r set while FIFO holds a write to r; bit 0 always 0
// BEHAVIOUR
//  Reset: regwrite=0, wa=0, wd=0, pending=0, b_ready=1, FIFO empty, starve count=0, state=NORM.
//  Latency: grant in cycle N -> regwrite/wa/wd valid in cycle N+1; one write per cycle max.
//  Writes to r0 (either port): accepted, no regwrite, never enqueued or set in pending.
//  B accept: b_valid&b_ready pushes {b_wa,b_wd}; b_ready=0 when FIFO full (count==FIFO_DEPTH).
//  FSM states:
//   NORM : a_ready=1 unless pending[a_wa] (order hazard) -> then a_ready=0.
//          A accepted -> A granted. Else FIFO non-empty -> head popped and granted.
//          Starve counter increments each cycle a non-empty FIFO head is not granted;
//          clears on pop or empty. Counter==STARVE_LIMIT-1 with head blocked -> FORCE.
//   FORCE: a_ready=0; head popped and granted; starve count cleared; -> NORM next cycle.
//  Order hazard: a_wa matching a pending entry stalls A until the FIFO drains that entry;
//   since A is then not granted, the FIFO pops each cycle, so the stall is bounded by FIFO_DEPTH.
//  Simultaneous push and pop: allowed; count unchanged. Push into an empty FIFO is not granted
//   in the same cycle (the head is registered), so earliest B write is 2 cycles after accept.
//  pending: set on push (if b_wa!=0), cleared on pop. Duplicate addresses use a per-register
//   counter-free rule: clear only if no other FIFO entry targets the same register.
//  Pointers wrap modulo FIFO_DEPTH; count width clog2(FIFO_DEPTH)+1.
//  Reset mid-operation: FIFO contents dropped, in-flight regwrite deasserted immediately (async).
// STRUCTURE
//  Shared package dmips_pkg: REG_ADDR_W=5, NUM_REGS=32, REG_ZERO=5'd0.
//  Sub-module wb_fifo (DATA_WIDTH+5 wide, FIFO_DEPTH deep, push/pop/full/empty/head).
//  Top: FSM, starve counter, pending scoreboard, output registers.
// TESTING
//  1 A only: a_wa=3, a_wd=0x14 -> next cycle regwrite=1, wa=3, wd=0x14; regfile rd1(3)=0x14.
//  2 B only: b_wa=4, b_wd=0x1d -> pending[4]=1, write seen 2 cycles later, pending[4]=0 after.
//  3 Hazard: push B (r5=0xAA), next cycle A (r5=0xBB) -> a_ready=0 until B write; final r5=0xBB.
//  4 Starvation: A valid every cycle (r6..), B push r7=0x77 -> B written within STARVE_LIMIT+1
//    cycles; a_ready=0 in that FORCE cycle only.
//  5 Full: 5 B pushes with A saturating, DEPTH=4 -> b_ready=0 after 4th; 5th waits, all 5 written in order.
//  6 r0 + reset: A write r0=0xFF -> regwrite stays 0; rst_n low with 3 queued -> pending=0,
//    b_ready=1, no further writes.

Source files
------------

// File: rtl/dmips_pkg.sv
// Shared register-file constants, the write-arbiter state type and a one-hot helper
// used to build the pending-write scoreboard.
package dmips_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic {
    ST_NORM  = 1'b0,
    ST_FORCE = 1'b1
  } arb_state_e;

  // r0 maps to no bit, so it can never appear as pending.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] r);
    reg_onehot = '0;
    if (r != REG_ZERO) reg_onehot[r] = 1'b1;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Port-B writeback buffer. It exposes every slot plus an occupancy mask so that the
// arbiter can see all queued destinations, not only the head.
module wb_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             din,
  output logic                         full,
  output logic                         empty,
  output logic [WIDTH-1:0]             head,
  output logic [DEPTH-1:0][WIDTH-1:0]  entries,
  output logic [DEPTH-1:0]             occupied
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0]             wr_ptr;
  logic [PW-1:0]             rd_ptr;
  logic [PW:0]               count;
  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [DEPTH-1:0]          occ;
  logic                      do_push;
  logic                      do_pop;

  assign full     = (count == (PW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign head     = mem[rd_ptr];
  assign entries  = mem;
  assign occupied = occ;

  // Push and pop never target the same slot: that needs empty or full, which blocks one side.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      occ    <= '0;
      mem    <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        occ[wr_ptr] <= 1'b1;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        occ[rd_ptr] <= 1'b0;
        rd_ptr      <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the single regfile write port between the pipeline (A, priority) and a buffered
// multi-cycle unit (B), with same-register ordering, anti-starvation and a pending scoreboard.
//
// state | meaning
// NORM  | A has priority unless its target is queued in B; otherwise the B head drains
// FORCE | B head waited too long: A is held off for one cycle and the head is written
module regfile_write_arbiter
  import dmips_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [4:0]            a_wa,
  input  logic [DATA_WIDTH-1:0] a_wd,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [4:0]            b_wa,
  input  logic [DATA_WIDTH-1:0] b_wd,
  output logic                  regwrite,
  output logic [4:0]            wa,
  output logic [DATA_WIDTH-1:0] wd,
  output logic [31:0]           pending
);

  localparam int EW = REG_ADDR_W + DATA_WIDTH;
  localparam int SW = $clog2(STARVE_LIMIT) + 1;

  arb_state_e                    state;
  arb_state_e                    state_nxt;
  logic [SW-1:0]                 starve_cnt;
  logic [SW-1:0]                 starve_nxt;
  logic                          fifo_full;
  logic                          fifo_empty;
  logic                          push;
  logic                          pop;
  logic                          grant_a;
  logic [EW-1:0]                 head;
  logic [FIFO_DEPTH-1:0][EW-1:0] entries;
  logic [FIFO_DEPTH-1:0]         occupied;
  logic [REG_ADDR_W-1:0]         head_wa;
  logic [DATA_WIDTH-1:0]         head_wd;

  assign b_ready = ~fifo_full;
  // r0 writes are accepted on B but simply dropped.
  assign push    = b_valid & ~fifo_full & (b_wa != REG_ZERO);
  assign head_wa = head[EW-1 -: REG_ADDR_W];
  assign head_wd = head[DATA_WIDTH-1:0];

  wb_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .pop      (pop),
    .din      ({b_wa, b_wd}),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (head),
    .entries  (entries),
    .occupied (occupied)
  );

  // Rebuilt from live slots, so a duplicate target stays pending until its last copy pops.
  always_comb begin
    pending = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (occupied[i]) pending = pending | reg_onehot(entries[i][EW-1 -: REG_ADDR_W]);
    end
  end

  always_comb begin
    state_nxt  = state;
    starve_nxt = starve_cnt;
    a_ready    = 1'b0;
    grant_a    = 1'b0;
    pop        = 1'b0;
    case (state)
      ST_NORM: begin
        a_ready = ~pending[a_wa];
        if (a_valid && a_ready) begin
          grant_a = 1'b1;
          if (fifo_empty)                                 starve_nxt = '0;
          else if (starve_cnt == SW'(STARVE_LIMIT - 1))   state_nxt  = ST_FORCE;
          else                                            starve_nxt = starve_cnt + 1'b1;
        end else begin
          pop        = ~fifo_empty;
          starve_nxt = '0;
        end
      end
      ST_FORCE: begin
        pop        = ~fifo_empty;
        starve_nxt = '0;
        state_nxt  = ST_NORM;
      end
      default: state_nxt = ST_NORM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_NORM;
      starve_cnt <= '0;
      regwrite   <= 1'b0;
      wa         <= '0;
      wd         <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      if (grant_a) begin
        regwrite <= (a_wa != REG_ZERO);
        wa       <= a_wa;
        wd       <= a_wd;
      end else if (pop) begin
        regwrite <= 1'b1;
        wa       <= head_wa;
        wd       <= head_wd;
      end else begin
        regwrite <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed stimulus feeds expected-write queues, and a
// negedge monitor matches every regfile write against them.
module tb_regfile_write_arbiter;
  import dmips_pkg::*;

  localparam int DW = 32;
  localparam int SL = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          a_valid = 1'b0, b_valid = 1'b0;
  logic          a_ready, b_ready, regwrite;
  logic [4:0]    a_wa = '0, b_wa = '0, wa;
  logic [DW-1:0] a_wd = '0, b_wd = '0, wd;
  logic [31:0]   pending;

  regfile_write_arbiter #(.DATA_WIDTH(DW), .FIFO_DEPTH(4), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_wa(a_wa), .a_wd(a_wd),
    .b_valid(b_valid), .b_ready(b_ready), .b_wa(b_wa), .b_wd(b_wd),
    .regwrite(regwrite), .wa(wa), .wd(wd), .pending(pending)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]    wa;
    logic [DW-1:0] wd;
  } wr_t;

  wr_t         qa[$];
  wr_t         qb[$];
  logic [31:0] rf [32];
  int          tests = 0;
  int          fails = 0;
  int          wr_count = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Per-source order is enforced by only accepting the head of either queue.
  always @(negedge clk) begin
    if (rst_n && regwrite) begin
      wr_count++;
      rf[wa] = wd;
      tests++;
      if (qa.size() > 0 && qa[0] == {wa, wd}) void'(qa.pop_front());
      else if (qb.size() > 0 && qb[0] == {wa, wd}) void'(qb.pop_front());
      else begin
        fails++;
        $display("FAIL write_match: got wa=%0d wd=%0h, expected A head %0h or B head %0h",
                 wa, wd, (qa.size() > 0) ? qa[0] : 37'h0, (qb.size() > 0) ? qb[0] : 37'h0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic [4:0] r, input logic [DW-1:0] d, output int stalls);
    a_valid = 1'b1; a_wa = r; a_wd = d;
    stalls = 0;
    @(negedge clk);
    while (!a_ready && stalls < 20) begin
      stalls++;
      @(negedge clk);
    end
    check("a_accept_bound", 64'(stalls < 20), 64'd1);
    if (r != 5'd0) qa.push_back({r, d});
    tick();
    a_valid = 1'b0;
  endtask

  task automatic push_b(input logic [4:0] r, input logic [DW-1:0] d);
    int n;
    b_valid = 1'b1; b_wa = r; b_wd = d;
    n = 0;
    @(negedge clk);
    while (!b_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("b_accept_bound", 64'(n < 100), 64'd1);
    if (r != 5'd0) qb.push_back({r, d});
    tick();
    b_valid = 1'b0;
  endtask

  initial begin
    int st, lo_cnt, lo_at, bi, seen_full, wr_snap;
    for (int i = 0; i < 32; i++) rf[i] = '0;

    #2;
    check("rst_regwrite", 64'(regwrite), 64'd0);
    check("rst_wa", 64'(wa), 64'd0);
    check("rst_wd", 64'(wd), 64'd0);
    check("rst_pending", 64'(pending), 64'd0);
    check("rst_b_ready", 64'(b_ready), 64'd1);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // A only: one-cycle latency
    drive_a(5'd3, 32'h14, st);
    check("a_only_stall", 64'(st), 64'd0);
    @(negedge clk);
    check("a_only_regwrite", 64'(regwrite), 64'd1);
    check("a_only_wa", 64'(wa), 64'd3);
    check("a_only_wd", 64'(wd), 64'h14);
    tick(); tick();
    check("a_only_rf3", 64'(rf[3]), 64'h14);

    // B only: pending while queued, write two cycles after accept
    push_b(5'd4, 32'h1d);
    @(negedge clk);
    check("b_only_pending_set", 64'(pending[4]), 64'd1);
    check("b_only_no_early_write", 64'(regwrite), 64'd0);
    @(negedge clk);
    check("b_only_regwrite", 64'(regwrite), 64'd1);
    check("b_only_wa", 64'(wa), 64'd4);
    check("b_only_wd", 64'(wd), 64'h1d);
    check("b_only_pending_clr", 64'(pending[4]), 64'd0);
    tick(); tick();

    // Same-register hazard: A must wait for the queued B write
    push_b(5'd5, 32'hAA);
    drive_a(5'd5, 32'hBB, st);
    check("hazard_stall_cycles", 64'(st), 64'd1);
    repeat (3) tick();
    check("hazard_final_r5", 64'(rf[5]), 64'hBB);

    // Starvation: A every cycle, one B entry gets a forced grant
    lo_cnt = 0; lo_at = -1;
    for (int i = 0; i < 14; i++) begin
      a_valid = 1'b1; a_wa = 5'd6; a_wd = 32'h600 + 32'(i);
      b_valid = (i == 0); b_wa = 5'd7; b_wd = 32'h77;
      @(negedge clk);
      if (a_ready) qa.push_back({5'd6, 32'h600 + 32'(i)});
      else begin lo_cnt++; lo_at = i; end
      if (i == 0) begin
        check("starve_b_ready", 64'(b_ready), 64'd1);
        qb.push_back({5'd7, 32'h77});
      end
      tick();
    end
    a_valid = 1'b0; b_valid = 1'b0;
    check("starve_force_cycles", 64'(lo_cnt), 64'd1);
    check("starve_force_at", 64'(lo_at), 64'(SL + 1));
    check("starve_r7_written", 64'(rf[7]), 64'h77);
    tick(); tick();

    // Full FIFO under A saturation: fifth push waits, all drain in order
    bi = 0; seen_full = 0;
    for (int i = 0; i < 150 && !(bi == 5 && qb.size() == 0); i++) begin
      a_valid = 1'b1; a_wa = 5'(16 + (i % 8)); a_wd = 32'hA000 + 32'(i);
      b_valid = (bi < 5); b_wa = 5'(10 + bi); b_wd = 32'hB0 + 32'(bi);
      @(negedge clk);
      if (bi == 4 && seen_full == 0) begin
        check("full_b_ready_low", 64'(b_ready), 64'd0);
        seen_full = 1;
      end
      if (a_ready) qa.push_back({a_wa, a_wd});
      if (b_valid && b_ready) begin
        qb.push_back({b_wa, b_wd});
        bi++;
      end
      tick();
    end
    a_valid = 1'b0; b_valid = 1'b0;
    check("full_all_pushed", 64'(bi), 64'd5);
    repeat (3) tick();
    check("full_b_drained", 64'(qb.size()), 64'd0);
    check("full_a_drained", 64'(qa.size()), 64'd0);
    check("full_r14", 64'(rf[14]), 64'hB4);

    // r0 write: accepted, never written
    drive_a(5'd0, 32'hFF, st);
    @(negedge clk);
    check("r0_no_regwrite", 64'(regwrite), 64'd0);
    tick();

    // Reset with three queued B writes
    for (int i = 0; i < 4; i++) begin
      a_valid = 1'b1; a_wa = 5'd20; a_wd = 32'hC00 + 32'(i);
      b_valid = (i < 3); b_wa = 5'(1 + i); b_wd = 32'hD0 + 32'(i);
      @(negedge clk);
      if (a_ready) qa.push_back({a_wa, a_wd});
      if (b_valid && b_ready) qb.push_back({b_wa, b_wd});
      if (i == 3) check("rst_pre_pending", 64'(pending), 64'h0000_000E);
      tick();
    end
    a_valid = 1'b0; b_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    qa.delete(); qb.delete();
    check("midrst_regwrite", 64'(regwrite), 64'd0);
    check("midrst_pending", 64'(pending), 64'd0);
    check("midrst_b_ready", 64'(b_ready), 64'd1);
    wr_snap = wr_count;
    tick(); tick();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) tick();
    check("midrst_no_writes", 64'(wr_count - wr_snap), 64'd0);
    check("midrst_pending_after", 64'(pending), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
